alu_seq_64: RTL
===============

Name: alu_seq_64

Overview:
- 64-bit execute-stage ALU sitting directly downstream of the ALU-source 2:1 mux.
- Operand A comes from register-file read port 1; operand B is the mux output (R2 or the sign-extended immediate).
- Single-cycle logic/add/sub ops have a registered result one cycle after start.
- MUL is multi-cycle: radix-2 shift-add, start/busy/done handshake.

Parameters:
- WIDTH, 64, datapath width for operands and result.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset; reset is asynchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A (register-file read 1).
- b  input  WIDTH  operand B (ALU-source mux output).
- alu_op  input  4  operation code.
- busy  output  1  high while a MUL is in progress.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  registered result; holds until the next done.
- zero  output  1  registered; equals (result == 0), updated with done.

Behaviour:
- Reset (async, rst_n low): state=IDLE, busy=0, done=0, result=0, zero=1, counter=0, internal operand registers=0.
- Reset mid-MUL aborts immediately; no done is produced.
- alu_op encoding:
  - 0000 AND; 0001 ORR; 0010 ADD; 0110 SUB (a-b).
  - 0111 PASSB (result=b); 1100 NOR.
  - 1000 MUL (low WIDTH bits of unsigned a*b).
  - Any other code: result=0, treated as a single-cycle op.
- ADD/SUB wrap modulo 2^WIDTH.
- States: IDLE, MUL, DONE.
- IDLE:
  - start=1 with a single-cycle op: at that edge register result/zero, go to DONE.
  - start=1 with MUL: latch a into multiplicand, b into multiplier, clear accumulator and counter, busy=1, go to MUL.
  - start=0: stay; done=0.
- MUL, one iteration per cycle:
  - if multiplier[0], acc += multiplicand.
  - multiplicand <<= 1; multiplier >>= 1; counter++.
  - After WIDTH iterations: result=acc, zero updated, busy=0, go to DONE.
  - start asserted during MUL is ignored (not queued).
  - a, b and alu_op may change freely after the start edge; operands are captured.
- DONE: done=1 for exactly this one cycle, then IDLE. start in DONE is ignored.
- Latency from the start edge to done high:
  - single-cycle op: done visible in the cycle after the start edge.
  - MUL: done visible WIDTH+1 cycles after the start edge.
- Back-to-back throughput: one op every 2 cycles minimum.
- result and zero are stable between done pulses.

Optional Feature:
- Macro ALU_FLAGS_EN.
- Defined:
  - Extra output port nzcv, 4 bits, registered with done, reset 4'b0100.
  - N = result MSB; Z = zero.
  - C = carry-out of ADD, or no-borrow (a>=b unsigned) for SUB.
  - V = signed overflow for ADD/SUB.
  - C=V=0 for all other ops.
- Undefined: no nzcv port and no flag logic; zero is still present.

Decomposition:
- Shared package alu_pkg holds:
  - alu_op localparams (ALU_AND, ALU_ORR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_NOR, ALU_MUL).
  - state encoding (S_IDLE, S_MUL, S_DONE).
  - WIDTH default.
- One natural sub-module: alu_comb_64, the purely combinational single-cycle op and flag evaluator. The top holds the FSM, MUL datapath and output registers.

Test Plan:
- Reset: hold rst_n=0 mid-run -> result=0, zero=1, busy=0, done=0 immediately, without waiting for a clock edge.
- ADD: a=2, b=3, alu_op=0010, start 1 cycle -> next cycle done=1, result=5, zero=0. With ALU_FLAGS_EN: nzcv=0000.
- SUB zero/borrow: a=7, b=7, alu_op=0110 -> result=0, zero=1, nzcv=0110. Then a=6, b=7 -> result=0xFFFF_FFFF_FFFF_FFFF, nzcv=1000.
- MUL: a=6, b=7, alu_op=1000 -> busy high for 64 cycles, done at cycle 65, result=42.
- MUL wrap: a=2^63, b=2 -> result=0, zero=1.
- Ignored start / abort: pulse start with ADD during MUL -> no extra done and MUL result unchanged. Assert rst_n low at MUL cycle 30 -> no done, state returns to IDLE.

Source files
------------

// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------------+
// | alu_pkg : shared opcodes, FSM state encoding and default datapath width    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam int ALU_WIDTH = 64;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_MUL   = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_comb_64.sv
// +----------------------------------------------------------------------------+
// | alu_comb_64 : combinational single-cycle op evaluator (+ C/V flags when    |
// |               ALU_FLAGS_EN is defined)                                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_comb_64 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op,
`ifdef ALU_FLAGS_EN
  output logic             o_c,
  output logic             o_v,
`endif
  output logic [WIDTH-1:0] o_res
);
  import alu_pkg::*;

  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_sub;

`ifdef ALU_FLAGS_EN
  // One extra bit captures carry-out; subtraction as a + ~b + 1 gives no-borrow.
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_add  = w_sum[WIDTH-1:0];
  assign w_sub  = w_diff[WIDTH-1:0];

  always_comb begin
    o_c = 1'b0;
    o_v = 1'b0;
    if (i_op == ALU_ADD) begin
      o_c = w_sum[WIDTH];
      o_v = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_add[WIDTH-1] != i_a[WIDTH-1]);
    end else if (i_op == ALU_SUB) begin
      o_c = w_diff[WIDTH];
      o_v = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_sub[WIDTH-1] != i_a[WIDTH-1]);
    end
  end
`else
  assign w_add = i_a + i_b;
  assign w_sub = i_a - i_b;
`endif

  always_comb begin
    o_res = '0;
    case (i_op)
      ALU_AND:   o_res = i_a & i_b;
      ALU_ORR:   o_res = i_a | i_b;
      ALU_ADD:   o_res = w_add;
      ALU_SUB:   o_res = w_sub;
      ALU_PASSB: o_res = i_b;
      ALU_NOR:   o_res = ~(i_a | i_b);
      default:   o_res = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq_64.sv
// +----------------------------------------------------------------------------+
// | alu_seq_64 : execute-stage ALU, single-cycle ops plus shift-add MUL.       |
// |              Optional nzcv flag output enabled by ALU_FLAGS_EN.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_seq_64 #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef ALU_FLAGS_EN
  output logic [3:0]       nzcv,
`endif
  output logic             zero
);
  import alu_pkg::*;

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

`ifdef ALU_FLAGS_EN
  logic w_c;
  logic w_v;
`endif

  alu_comb_64 #(.WIDTH(WIDTH)) u_comb (
    .i_a   (a),
    .i_b   (b),
    .i_op  (alu_op),
`ifdef ALU_FLAGS_EN
    .o_c   (w_c),
    .o_v   (w_v),
`endif
    .o_res (w_res)
  );

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b1;
`ifdef ALU_FLAGS_EN
      nzcv     <= 4'b0100;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (alu_op == ALU_MUL) begin
              r_mcand  <= a;
              r_mplier <= b;
              r_acc    <= '0;
              r_cnt    <= '0;
              busy     <= 1'b1;
              r_state  <= S_MUL;
            end else begin
              result  <= w_res;
              zero    <= (w_res == '0);
`ifdef ALU_FLAGS_EN
              nzcv    <= {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
`endif
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          // The final iteration's sum goes straight to the output register.
          if (w_last) begin
            result  <= w_acc_next;
            zero    <= (w_acc_next == '0);
`ifdef ALU_FLAGS_EN
            nzcv    <= {w_acc_next[WIDTH-1], (w_acc_next == '0), 2'b00};
`endif
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
